// File: rtl/forex_pkg.sv
// Shared types and constants for the edge-update path into the Container.
// Address map, STATUS bit positions and default widths live here.
package forex_pkg;

    localparam int PRED_W_DEF   = 6;
    localparam int WEIGHT_W_DEF = 32;
    localparam int DEPTH_DEF    = 16;

    localparam logic [2:0] ADDR_PAIR   = 3'd0;
    localparam logic [2:0] ADDR_WEIGHT = 3'd1;
    localparam logic [2:0] ADDR_CTRL   = 3'd2;
    localparam logic [2:0] ADDR_STATUS = 3'd3;

    localparam int ST_EMPTY    = 0;
    localparam int ST_FULL     = 1;
    localparam int ST_STAGED   = 2;
    localparam int ST_OVERFLOW = 3;
    localparam int ST_ORPHAN   = 4;
    localparam int ST_SELFLOOP = 5;
    localparam int ST_CNT_LSB  = 8;
    localparam int ST_DROP_LSB = 16;

    typedef struct packed {
        logic [PRED_W_DEF-1:0]   src;
        logic [PRED_W_DEF-1:0]   dst;
        logic [WEIGHT_W_DEF-1:0] e;
    } edge_update_t;

endpackage

// File: rtl/edge_update_queue_if.sv
// Avalon-MM slave bus plus the valid/ready update stream to the Container.
interface edge_update_queue_if #(
    parameter int PRED_W   = 6,
    parameter int WEIGHT_W = 32,
    parameter int DEPTH    = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                chipselect;
    logic                write;
    logic                read;
    logic [2:0]          address;
    logic [31:0]         writedata;
    logic [31:0]         readdata;
    logic                upd_valid;
    logic                upd_ready;
    logic [PRED_W-1:0]   upd_src;
    logic [PRED_W-1:0]   upd_dst;
    logic [WEIGHT_W-1:0] upd_e;
    logic [CW-1:0]       q_count;

    modport slave (
        input  chipselect, write, read, address, writedata, upd_ready,
        output readdata, upd_valid, upd_src, upd_dst, upd_e, q_count
    );

    modport master (
        output chipselect, write, read, address, writedata, upd_ready,
        input  readdata, upd_valid, upd_src, upd_dst, upd_e, q_count
    );

endinterface

// File: rtl/edge_update_queue_fifo.sv
// Generic show-ahead FIFO with registered head/valid, push/pop/flush and count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic [CW-1:0]    o_count
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd, r_wr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_head;
    logic             r_valid;

    logic             w_pop, w_push, w_fwd;
    logic [AW-1:0]    w_rd_n;
    logic [CW-1:0]    w_left, w_cnt_n;
    logic [WIDTH-1:0] w_head_n;

    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && !i_flush &&
                    ((r_count != CW'(DEPTH)) || w_pop);

    always_comb begin
        w_rd_n   = r_rd + AW'(w_pop);
        w_left   = r_count - CW'(w_pop);
        w_cnt_n  = w_left + CW'(w_push);
        // new entry becomes head when nothing older survives the pop
        w_fwd    = w_push && (w_left == '0);
        w_head_n = w_fwd ? i_data : r_mem[w_rd_n];
        if (i_flush) w_cnt_n = '0;
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            r_head  <= '0;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
        end else begin
            r_rd    <= w_rd_n;
            r_wr    <= r_wr + AW'(w_push);
            r_count <= w_cnt_n;
            r_valid <= (w_cnt_n != '0);
            if (w_push || w_pop) r_head <= w_head_n;
        end
    end

    assign o_data  = r_head;
    assign o_valid = r_valid;
    assign o_count = r_count;

endmodule

// File: rtl/edge_update_queue.sv
// Avalon-fed edge-update queue: stages a vertex pair, commits it with a weight.
// Build option: define EDGE_Q_DROP_CNT_EN for a saturating rejected-write counter.
module edge_update_queue
    import forex_pkg::*;
#(
    parameter int PRED_W   = PRED_W_DEF,
    parameter int WEIGHT_W = WEIGHT_W_DEF,
    parameter int DEPTH    = DEPTH_DEF
) (
    input logic          clk,
    input logic          reset,
    edge_update_queue_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = 2 * PRED_W + WEIGHT_W;

    logic [PRED_W-1:0] r_src, r_dst;
    logic              r_staged;
    logic              r_ovf, r_orph, r_self;
    logic [31:0]       r_rdata;

    logic          w_wr, w_rd;
    logic          w_pair, w_weight, w_ctrl;
    logic          w_flush, w_clr;
    logic          w_valid, w_pop, w_space, w_push, w_reject;
    logic [CW-1:0] w_count;
    logic [EW-1:0] w_din, w_head;
    logic [15:0]   w_drop;
    logic [31:0]   w_status;

    assign w_wr     = bus.chipselect & bus.write;
    assign w_rd     = bus.chipselect & bus.read;
    assign w_pair   = w_wr && (bus.address == ADDR_PAIR);
    assign w_weight = w_wr && (bus.address == ADDR_WEIGHT);
    assign w_ctrl   = w_wr && (bus.address == ADDR_CTRL);
    assign w_flush  = w_ctrl & bus.writedata[0];
    assign w_clr    = w_ctrl & bus.writedata[1];

    assign w_pop    = w_valid & bus.upd_ready;
    assign w_space  = (w_count != CW'(DEPTH)) || w_pop;
    assign w_push   = w_weight & r_staged & (r_src != r_dst) & w_space;
    assign w_reject = w_weight & ~w_push;
    assign w_din    = {r_src, r_dst, bus.writedata[WEIGHT_W-1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_src    <= '0;
            r_dst    <= '0;
            r_staged <= 1'b0;
        end else if (w_pair) begin
            r_src    <= bus.writedata[2*PRED_W-1:PRED_W];
            r_dst    <= bus.writedata[PRED_W-1:0];
            r_staged <= 1'b1;
        end else if (w_weight || w_flush) begin
            r_staged <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf  <= 1'b0;
            r_orph <= 1'b0;
            r_self <= 1'b0;
        end else if (w_clr) begin
            r_ovf  <= 1'b0;
            r_orph <= 1'b0;
            r_self <= 1'b0;
        end else if (w_weight) begin
            if (!r_staged)           r_orph <= 1'b1;
            else if (r_src == r_dst) r_self <= 1'b1;
            else if (!w_space)       r_ovf  <= 1'b1;
        end
    end

`ifdef EDGE_Q_DROP_CNT_EN
    logic [15:0] r_drop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_drop <= '0;
        else if (w_clr)
            r_drop <= '0;
        else if (w_reject && (r_drop != 16'hFFFF))
            r_drop <= r_drop + 16'd1;
    end

    assign w_drop = r_drop;
`else
    assign w_drop = '0;
`endif

    always_comb begin
        w_status                          = '0;
        w_status[ST_EMPTY]                = (w_count == '0);
        w_status[ST_FULL]                 = (w_count == CW'(DEPTH));
        w_status[ST_STAGED]               = r_staged;
        w_status[ST_OVERFLOW]             = r_ovf;
        w_status[ST_ORPHAN]               = r_orph;
        w_status[ST_SELFLOOP]             = r_self;
        w_status[ST_CNT_LSB +: 8]         = 8'(w_count);
        w_status[ST_DROP_LSB +: 16]       = w_drop;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_rdata <= '0;
        else if (w_rd)
            r_rdata <= (bus.address == ADDR_STATUS) ? w_status : '0;
    end

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_data  (w_din),
        .o_data  (w_head),
        .o_valid (w_valid),
        .o_count (w_count)
    );

    assign bus.readdata  = r_rdata;
    assign bus.upd_valid = w_valid;
    assign bus.upd_src   = w_head[EW-1 -: PRED_W];
    assign bus.upd_dst   = w_head[WEIGHT_W +: PRED_W];
    assign bus.upd_e     = w_head[WEIGHT_W-1:0];
    assign bus.q_count   = w_count;

endmodule

// File: tb/tb_edge_update_queue.sv
// Directed plus randomized bench for edge_update_queue against a queue model.
module tb_edge_update_queue;
    import forex_pkg::*;

    localparam int PW = 6;
    localparam int WW = 32;
    localparam int D  = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    edge_update_queue_if #(.PRED_W(PW), .WEIGHT_W(WW), .DEPTH(D)) bus();

    edge_update_queue #(.PRED_W(PW), .WEIGHT_W(WW), .DEPTH(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    edge_update_t mq[$];
    bit           m_staged, m_ovf, m_orph, m_self;
    int           m_src, m_dst, m_drop;
    logic [31:0]  m_rd;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        mq.delete();
        m_staged = 0; m_ovf = 0; m_orph = 0; m_self = 0;
        m_src = 0; m_dst = 0; m_drop = 0; m_rd = '0;
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s        = '0;
        s[0]     = (mq.size() == 0);
        s[1]     = (mq.size() == D);
        s[2]     = m_staged;
        s[3]     = m_ovf;
        s[4]     = m_orph;
        s[5]     = m_self;
        s[15:8]  = 8'(mq.size());
`ifdef EDGE_Q_DROP_CNT_EN
        s[31:16] = 16'(m_drop);
`endif
        return s;
    endfunction

    task automatic m_drop_inc();
`ifdef EDGE_Q_DROP_CNT_EN
        if (m_drop < 65535) m_drop++;
`endif
    endtask

    task automatic m_edge();
        logic [31:0]  st, wd;
        bit           pop, push, flush;
        edge_update_t ne;
        st    = m_status();
        wd    = bus.writedata;
        pop   = (mq.size() != 0) && bus.upd_ready;
        push  = 0;
        flush = 0;
        ne    = '0;
        if (bus.chipselect && bus.read)
            m_rd = (bus.address == 3'd3) ? st : 32'h0;
        if (bus.chipselect && bus.write) begin
            case (bus.address)
                3'd0: begin
                    m_src = int'(wd[11:6]);
                    m_dst = int'(wd[5:0]);
                    m_staged = 1;
                end
                3'd1: begin
                    if (!m_staged) begin
                        m_orph = 1; m_drop_inc();
                    end else if (m_src == m_dst) begin
                        m_self = 1; m_staged = 0; m_drop_inc();
                    end else if (mq.size() < D || pop) begin
                        push = 1; m_staged = 0;
                        ne.src = 6'(m_src); ne.dst = 6'(m_dst); ne.e = wd;
                    end else begin
                        m_ovf = 1; m_staged = 0; m_drop_inc();
                    end
                end
                3'd2: begin
                    if (wd[0]) begin flush = 1; m_staged = 0; end
                    if (wd[1]) begin
                        m_ovf = 0; m_orph = 0; m_self = 0; m_drop = 0;
                    end
                end
                default: ;
            endcase
        end
        if (flush) mq.delete();
        else begin
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back(ne);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        m_edge();
        #1;
        chk("valid", 32'(bus.upd_valid), 32'(mq.size() != 0));
        chk("count", 32'(bus.q_count), 32'(mq.size()));
        chk("readdata", bus.readdata, m_rd);
        if (mq.size() != 0) begin
            chk("upd_src", 32'(bus.upd_src), 32'(mq[0].src));
            chk("upd_dst", 32'(bus.upd_dst), 32'(mq[0].dst));
            chk("upd_e", bus.upd_e, mq[0].e);
        end
    endtask

    task automatic op(bit w, bit r, logic [2:0] a, logic [31:0] d);
        bus.chipselect = w | r;
        bus.write      = w;
        bus.read       = r;
        bus.address    = a;
        bus.writedata  = d;
        tick();
        bus.chipselect = 0;
        bus.write      = 0;
        bus.read       = 0;
    endtask

    task automatic push_edge(int s, int t, logic [31:0] e);
        op(1, 0, 3'd0, 32'((s << 6) | t));
        op(1, 0, 3'd1, e);
    endtask

    initial begin
        logic [31:0] exp_full;
        int          rp;
        bus.chipselect = 0; bus.write = 0; bus.read = 0;
        bus.address = '0; bus.writedata = '0; bus.upd_ready = 0;
        m_reset();
        #22;
        chk("rst_valid", 32'(bus.upd_valid), 32'h0);
        chk("rst_count", 32'(bus.q_count), 32'h0);
        chk("rst_rdata", bus.readdata, 32'h0);
        chk("rst_src", 32'(bus.upd_src), 32'h0);
        chk("rst_dst", 32'(bus.upd_dst), 32'h0);
        chk("rst_e", bus.upd_e, 32'h0);
        reset = 0;
        tick();
        op(0, 1, 3'd3, 32'h0);
        chk("rst_status", bus.readdata, 32'h1);

        op(1, 0, 3'd0, 32'h0102);
        op(1, 0, 3'd1, 32'hFFFF_FF80);
        chk("lat_valid", 32'(bus.upd_valid), 32'h1);
        chk("lat_src", 32'(bus.upd_src), 32'd4);
        chk("lat_dst", 32'(bus.upd_dst), 32'd2);
        chk("lat_e", bus.upd_e, 32'hFFFF_FF80);
        repeat (10) tick();
        chk("hold_e", bus.upd_e, 32'hFFFF_FF80);
        bus.upd_ready = 1;
        tick();
        chk("pop_valid", 32'(bus.upd_valid), 32'h0);
        bus.upd_ready = 0;

        for (int i = 1; i <= 16; i++) push_edge(i, i + 20, 32'(i * 32'h101));
        push_edge(30, 31, 32'h17);
        op(0, 1, 3'd3, 32'h0);
        exp_full = 32'h0000_100A;
`ifdef EDGE_Q_DROP_CNT_EN
        exp_full = exp_full | 32'h0001_0000;
`endif
        chk("full_status", bus.readdata, exp_full);
        bus.upd_ready = 1;
        repeat (17) tick();
        bus.upd_ready = 0;

        op(1, 0, 3'd2, 32'h2);
        for (int i = 1; i <= 16; i++) push_edge(i + 40, i, 32'(~i));
        op(1, 0, 3'd0, 32'((5 << 6) | 6));
        bus.upd_ready = 1;
        op(1, 0, 3'd1, 32'hAA);
        bus.upd_ready = 0;
        op(0, 1, 3'd3, 32'h0);
        chk("simul_status", bus.readdata, 32'h0000_1002);
        bus.upd_ready = 1;
        repeat (17) tick();
        bus.upd_ready = 0;

        op(1, 0, 3'd1, 32'h55);
        op(0, 1, 3'd3, 32'h0);
        push_edge(3, 3, 32'h66);
        op(0, 1, 3'd3, 32'h0);
        op(1, 0, 3'd2, 32'h2);
        op(0, 1, 3'd3, 32'h0);
        chk("clr_status", bus.readdata, 32'h1);

        for (int i = 0; i < 5; i++) push_edge(i, i + 1, 32'(i + 100));
        op(1, 0, 3'd0, 32'h0101);
        op(1, 0, 3'd2, 32'h1);
        chk("flush_valid", 32'(bus.upd_valid), 32'h0);
        op(0, 1, 3'd3, 32'h0);
        push_edge(9, 10, 32'hBEEF);
        tick();

        for (int i = 0; i < 3; i++) push_edge(i + 1, i + 7, 32'(i + 200));
        bus.upd_ready = 1;
        tick();
        #2 reset = 1;
        m_reset();
        #1;
        chk("async_valid", 32'(bus.upd_valid), 32'h0);
        chk("async_count", 32'(bus.q_count), 32'h0);
        bus.upd_ready = 0;
        @(negedge clk);
        reset = 0;
        tick();
        op(0, 1, 3'd3, 32'h0);
        chk("post_rst_status", bus.readdata, 32'h1);

        for (int blk = 0; blk < 8; blk++) begin
            for (int n = 0; n < 80; n++) begin
                rp = (blk % 2 == 1) ? 10 : 70;
                bus.upd_ready = ($urandom_range(0, 99) < rp);
                case ($urandom_range(0, 99)) inside
                    [0:34]:  op(1, 0, 3'd0,
                                32'(($urandom_range(0, 7) << 6) | $urandom_range(0, 7)));
                    [35:69]: op(1, 0, 3'd1, $urandom);
                    [70:71]: op(1, 0, 3'd2, 32'($urandom_range(0, 3)));
                    [72:84]: op(0, 1, 3'($urandom_range(0, 7)), 32'h0);
                    [85:89]: op(1, 0, 3'($urandom_range(3, 7)), $urandom);
                    default: tick();
                endcase
            end
        end
        bus.upd_ready = 0;
        op(0, 1, 3'd3, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
